// File: rtl/fft_r22sdf_pkg.sv
// Shared constants and helpers for the radix-2^2 single-path delay-feedback FFT stage.
package fft_r22sdf_pkg;

    localparam int NUM_STAGE_N = 6;
    localparam int LEGAL_STAGE_N [NUM_STAGE_N] = '{32'd4, 32'd16, 32'd64, 32'd256, 32'd1024, 32'd4096};

    // Delay lines up to this depth stay in shift-register form; deeper ones become a RAM ring.
    localparam int SRL_MAX_DEPTH = 32'd64;

    // Widest component carried by the generic complex sample; users narrow with their own width.
    localparam int CPLX_MAX_W = 32'd32;

    typedef struct packed {
        logic signed [CPLX_MAX_W-1:0] re;
        logic signed [CPLX_MAX_W-1:0] im;
    } cplx_t;

    function automatic int clog2(input int value);
        int r;
        r = 32'd0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 32'd1;
        end
        return r;
    endfunction

    function automatic bit is_legal_stage_n(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_STAGE_N; i++) begin
            if (LEGAL_STAGE_N[i] == n) begin
                ok = 1'b1;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/fft_r22sdf_dly.sv
// Enable-gated feedback delay of DEPTH samples; head is the sample pushed DEPTH enables ago.
module fft_r22sdf_dly
    import fft_r22sdf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head
);

    generate
        if (DEPTH <= SRL_MAX_DEPTH) begin : g_srl
            logic [WIDTH-1:0] taps_r [DEPTH];

            // Shift chain advanced on enabled beats only.
            always_ff @(posedge clk) begin
                if (en) begin
                    taps_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        taps_r[i] <= taps_r[i-1];
                    end
                end
            end

            assign head = taps_r[DEPTH-1];
        end else begin : g_ram
            localparam int AW = clog2(DEPTH);
            logic [WIDTH-1:0] mem_r [DEPTH];
            logic [AW-1:0]    ptr_r;

            // Read-then-overwrite at one ring pointer yields exactly DEPTH beats of delay.
            always_ff @(posedge clk) begin
                if (en) begin
                    mem_r[ptr_r] <= din;
                    if (ptr_r == AW'(DEPTH - 1)) begin
                        ptr_r <= '0;
                    end else begin
                        ptr_r <= ptr_r + {{(AW-1){1'b0}}, 1'b1};
                    end
                end
            end

            assign head = mem_r[ptr_r];
        end
    endgenerate

endmodule

// File: rtl/fft_r22sdf_stage.sv
// Radix-2^2 SDF FFT stage: BF I, trivial -j rotation, BF II, registered outputs.
// Build macro FFT_R22SDF_STAGE_SCALE_EN halves every butterfly result with round-half-up.
module fft_r22sdf_stage
    import fft_r22sdf_pkg::*;
#(
    parameter int  DATA_WIDTH = 14,
    parameter int  STAGE_N    = 1024,
    localparam int L          = clog2(STAGE_N),
    localparam int OUT_WIDTH  = DATA_WIDTH + 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] data_re_i,
    input  logic signed [DATA_WIDTH-1:0] data_im_i,
    output logic                         valid_o,
    output logic [L-1:0]                 ctr_o,
    output logic signed [OUT_WIDTH-1:0]  data_re_o,
    output logic signed [OUT_WIDTH-1:0]  data_im_o
);

    localparam int W1 = DATA_WIDTH + 1;
    localparam int W2 = OUT_WIDTH;
    localparam logic [L-1:0] LAT_BEATS = L'(32'd3 * STAGE_N / 32'd4);
    localparam logic [L-1:0] CTR_ONE   = {{(L-1){1'b0}}, 1'b1};

`ifdef FFT_R22SDF_STAGE_SCALE_EN
    function automatic logic signed [W1:0] scale1(input logic signed [W1:0] x);
        logic signed [W1:0] t;
        t = x + $signed({{W1{1'b0}}, 1'b1});
        return t >>> 1'b1;
    endfunction

    function automatic logic signed [W2:0] scale2(input logic signed [W2:0] x);
        logic signed [W2:0] t;
        t = x + $signed({{W2{1'b0}}, 1'b1});
        return t >>> 1'b1;
    endfunction
`else
    function automatic logic signed [W1:0] scale1(input logic signed [W1:0] x);
        return x;
    endfunction

    function automatic logic signed [W2:0] scale2(input logic signed [W2:0] x);
        return x;
    endfunction
`endif

    logic [L-1:0]         ctr_r;
    logic [L-1:0]         prime_cnt_r;
    logic                 primed_s;
    logic                 adv_s;

    logic [2*W1-1:0]      dly1_din_s;
    logic [2*W1-1:0]      dly1_head_s;
    logic signed [W1-1:0] h1_re_s, h1_im_s;
    logic signed [W1:0]   h1x_re_s, h1x_im_s, in1_re_s, in1_im_s;
    logic signed [W1:0]   sum1_re_s, sum1_im_s, dif1_re_s, dif1_im_s;
    logic signed [W1-1:0] bf1_re_s, bf1_im_s, push1_re_s, push1_im_s;
    logic signed [W1-1:0] rot_re_s, rot_im_s;

    logic [2*W2-1:0]      dly2_din_s;
    logic [2*W2-1:0]      dly2_head_s;
    logic signed [W2-1:0] h2_re_s, h2_im_s;
    logic signed [W2:0]   h2x_re_s, h2x_im_s, in2_re_s, in2_im_s;
    logic signed [W2:0]   sum2_re_s, sum2_im_s, dif2_re_s, dif2_im_s;
    logic signed [W2-1:0] bf2_re_s, bf2_im_s, push2_re_s, push2_im_s;

    assign adv_s    = valid_i & ~rst_i;
    assign primed_s = (prime_cnt_r == LAT_BEATS);

    assign {h1_re_s, h1_im_s} = dly1_head_s;
    assign h1x_re_s = {h1_re_s[W1-1], h1_re_s};
    assign h1x_im_s = {h1_im_s[W1-1], h1_im_s};
    assign in1_re_s = {{2{data_re_i[DATA_WIDTH-1]}}, data_re_i};
    assign in1_im_s = {{2{data_im_i[DATA_WIDTH-1]}}, data_im_i};

    // BF I: first half of a frame fills the delay, second half emits sums and stores differences.
    always_comb begin
        sum1_re_s  = scale1(h1x_re_s + in1_re_s);
        sum1_im_s  = scale1(h1x_im_s + in1_im_s);
        dif1_re_s  = scale1(h1x_re_s - in1_re_s);
        dif1_im_s  = scale1(h1x_im_s - in1_im_s);
        bf1_re_s   = h1_re_s;
        bf1_im_s   = h1_im_s;
        push1_re_s = in1_re_s[W1-1:0];
        push1_im_s = in1_im_s[W1-1:0];
        if (ctr_r[L-1]) begin
            bf1_re_s   = sum1_re_s[W1-1:0];
            bf1_im_s   = sum1_im_s[W1-1:0];
            push1_re_s = dif1_re_s[W1-1:0];
            push1_im_s = dif1_im_s[W1-1:0];
        end else begin
            bf1_re_s   = h1_re_s;
            bf1_im_s   = h1_im_s;
            push1_re_s = in1_re_s[W1-1:0];
            push1_im_s = in1_im_s[W1-1:0];
        end
    end

    assign dly1_din_s = {push1_re_s, push1_im_s};

    // Quarter 1 carries a BF I difference, so negating it cannot overflow.
    always_comb begin
        rot_re_s = bf1_re_s;
        rot_im_s = bf1_im_s;
        if (ctr_r[L-1:L-2] == 2'b01) begin
            rot_re_s = bf1_im_s;
            rot_im_s = -bf1_re_s;
        end else begin
            rot_re_s = bf1_re_s;
            rot_im_s = bf1_im_s;
        end
    end

    assign {h2_re_s, h2_im_s} = dly2_head_s;
    assign h2x_re_s = {h2_re_s[W2-1], h2_re_s};
    assign h2x_im_s = {h2_im_s[W2-1], h2_im_s};
    assign in2_re_s = {{2{rot_re_s[W1-1]}}, rot_re_s};
    assign in2_im_s = {{2{rot_im_s[W1-1]}}, rot_im_s};

    // BF II: same fill / sum-and-difference rule on quarter-frame boundaries.
    always_comb begin
        sum2_re_s  = scale2(h2x_re_s + in2_re_s);
        sum2_im_s  = scale2(h2x_im_s + in2_im_s);
        dif2_re_s  = scale2(h2x_re_s - in2_re_s);
        dif2_im_s  = scale2(h2x_im_s - in2_im_s);
        bf2_re_s   = h2_re_s;
        bf2_im_s   = h2_im_s;
        push2_re_s = in2_re_s[W2-1:0];
        push2_im_s = in2_im_s[W2-1:0];
        if (ctr_r[L-2]) begin
            bf2_re_s   = sum2_re_s[W2-1:0];
            bf2_im_s   = sum2_im_s[W2-1:0];
            push2_re_s = dif2_re_s[W2-1:0];
            push2_im_s = dif2_im_s[W2-1:0];
        end else begin
            bf2_re_s   = h2_re_s;
            bf2_im_s   = h2_im_s;
            push2_re_s = in2_re_s[W2-1:0];
            push2_im_s = in2_im_s[W2-1:0];
        end
    end

    assign dly2_din_s = {push2_re_s, push2_im_s};

    fft_r22sdf_dly #(
        .WIDTH (2 * W1),
        .DEPTH (STAGE_N / 2)
    ) u_dly1 (
        .clk  (clk_i),
        .en   (adv_s),
        .din  (dly1_din_s),
        .head (dly1_head_s)
    );

    fft_r22sdf_dly #(
        .WIDTH (2 * W2),
        .DEPTH (STAGE_N / 4)
    ) u_dly2 (
        .clk  (clk_i),
        .en   (adv_s),
        .din  (dly2_din_s),
        .head (dly2_head_s)
    );

    // Frame counter, priming count and output registers; data only moves once primed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctr_r       <= '0;
            prime_cnt_r <= '0;
            valid_o     <= 1'b0;
            ctr_o       <= '0;
            data_re_o   <= '0;
            data_im_o   <= '0;
        end else begin
            valid_o <= valid_i & primed_s;
            if (valid_i) begin
                ctr_r <= ctr_r + CTR_ONE;
                if (!primed_s) begin
                    prime_cnt_r <= prime_cnt_r + CTR_ONE;
                end
                if (primed_s) begin
                    ctr_o     <= ctr_r - LAT_BEATS;
                    data_re_o <= bf2_re_s;
                    data_im_o <= bf2_im_s;
                end
            end
        end
    end

endmodule
